// File: rtl/halo_exchange_scheduler_pkg.sv
// Shared PPU types for the neighbour-exchange phase: FSM states, neighbour count
// and compass-direction indices.
package ppu_pkg;
  localparam int NEIGHBOR_COUNT = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_PEERS, DONE} exch_state_t;

  typedef logic [2:0] neighbor_dir_t;

  localparam neighbor_dir_t N  = 3'd0;
  localparam neighbor_dir_t NE = 3'd1;
  localparam neighbor_dir_t E  = 3'd2;
  localparam neighbor_dir_t SE = 3'd3;
  localparam neighbor_dir_t S  = 3'd4;
  localparam neighbor_dir_t SW = 3'd5;
  localparam neighbor_dir_t W  = 3'd6;
  localparam neighbor_dir_t NW = 3'd7;
endpackage

// File: rtl/halo_exchange_scheduler_if.sv
// Halo producer stream: one beat per valid/ready handshake, addressed to a neighbour.
interface halo_exchange_scheduler_if
  import ppu_pkg::*;
#(
  parameter int RW = 8
);
  logic          halo_valid;
  logic          halo_last;
  neighbor_dir_t halo_dir;
  logic [7:0]    halo_value;
  logic [RW-1:0] halo_row;
  logic [RW-1:0] halo_col;
  logic          halo_ready;

  modport master (
    output halo_valid, halo_last, halo_dir, halo_value, halo_row, halo_col,
    input  halo_ready
  );

  modport slave (
    input  halo_valid, halo_last, halo_dir, halo_value, halo_row, halo_col,
    output halo_ready
  );
endinterface

// File: rtl/halo_exchange_scheduler_router.sv
// Registered 1-of-8 demux of an accepted halo beat onto the neighbour output ports.
module halo_output_router
  import ppu_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_p0,
  input  neighbor_dir_t                       dir_p0,
  input  logic [7:0]                          value_p0,
  input  logic [RW-1:0]                       row_p0,
  input  logic [RW-1:0]                       col_p0,
  output logic [NEIGHBOR_COUNT-1:0][7:0]      neighbor_output_value,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]   neighbor_output_row,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]   neighbor_output_column,
  output logic [NEIGHBOR_COUNT-1:0]           neighbor_output_write_enable
);
  logic [NEIGHBOR_COUNT-1:0][7:0]    value_p1;
  logic [NEIGHBOR_COUNT-1:0][RW-1:0] row_p1;
  logic [NEIGHBOR_COUNT-1:0][RW-1:0] col_p1;
  logic [NEIGHBOR_COUNT-1:0]         vld_p1;

  // p0 -> p1: only the addressed lane updates; the others keep their last payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_p1 <= '0;
      row_p1   <= '0;
      col_p1   <= '0;
      vld_p1   <= '0;
    end else begin
      vld_p1 <= '0;
      if (wr_p0) begin
        vld_p1[dir_p0]   <= 1'b1;
        value_p1[dir_p0] <= value_p0;
        row_p1[dir_p0]   <= row_p0;
        col_p1[dir_p0]   <= col_p0;
      end
    end
  end

  assign neighbor_output_value        = value_p1;
  assign neighbor_output_row          = row_p1;
  assign neighbor_output_column       = col_p1;
  assign neighbor_output_write_enable = vld_p1;
endmodule

// File: rtl/halo_exchange_scheduler.sv
// Sequences one channel group's neighbour-exchange phase: stream halo beats out,
// then wait for peers and incoming leftovers before signalling cycle_done.
module halo_exchange_scheduler
  import ppu_pkg::*;
#(
  parameter  int TILE_SIZE      = 256,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int RW             = $clog2(TILE_SIZE)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               channel_group_done,
  input  logic                               halo_pending,
  input  logic [NEIGHBOR_COUNT-1:0]          neighbor_present,
  halo_exchange_scheduler_if.slave           hif,
  input  logic [NEIGHBOR_COUNT-1:0]          neighbor_cts,
  input  logic [NEIGHBOR_COUNT-1:0]          neighbor_exchange_done,
  input  logic                               leftover_inputs,
  output logic [NEIGHBOR_COUNT-1:0][7:0]     neighbor_output_value,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]  neighbor_output_row,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]  neighbor_output_column,
  output logic [NEIGHBOR_COUNT-1:0]          neighbor_output_write_enable,
  output logic                               exchange_done,
  output logic                               cycle_done,
  output logic                               busy,
  output logic [15:0]                        dropped_count,
  output logic                               err_overrun,
  output logic                               err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  exch_state_t   state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          wr_p0;
  logic          peers_clear;
  logic          timeout_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Beats to absent neighbours are always accepted so they can be dropped
  assign hif.halo_ready = (state == SEND) &&
                          (neighbor_cts[hif.halo_dir] || !neighbor_present[hif.halo_dir]);
  assign accept = hif.halo_valid && hif.halo_ready;
  assign wr_p0  = accept && neighbor_present[hif.halo_dir];

  // Pending enables mean the last write is still in flight to the neighbour
  assign peers_clear = ((neighbor_exchange_done | ~neighbor_present) == 8'hFF) &&
                       !leftover_inputs && !(|neighbor_output_write_enable);
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  assign busy       = (state != IDLE);
  assign cycle_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (channel_group_done) state_nxt = halo_pending ? SEND : WAIT_PEERS;
      SEND:       if (accept && hif.halo_last) state_nxt = WAIT_PEERS;
      WAIT_PEERS: if (peers_clear || timeout_hit) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      exchange_done <= 1'b0;
      dropped_count <= '0;
      err_overrun   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (channel_group_done && state != IDLE) err_overrun <= 1'b1;
      case (state)
        IDLE: if (channel_group_done) begin
          dropped_count <= '0;
          tcnt          <= '0;
          if (!halo_pending) exchange_done <= 1'b1;
        end
        SEND: begin
          if (accept && !neighbor_present[hif.halo_dir]) dropped_count <= sat_inc16(dropped_count);
          if (accept && hif.halo_last) exchange_done <= 1'b1;
        end
        WAIT_PEERS: if (!peers_clear) begin
          if (timeout_hit) err_timeout <= 1'b1;
          else             tcnt        <= tcnt + 1'b1;
        end
        DONE:    exchange_done <= 1'b0;
        default: ;
      endcase
    end
  end

  halo_output_router #(.RW(RW)) u_router (
    .clk                          (clk),
    .reset                        (reset),
    .wr_p0                        (wr_p0),
    .dir_p0                       (hif.halo_dir),
    .value_p0                     (hif.halo_value),
    .row_p0                       (hif.halo_row),
    .col_p0                       (hif.halo_col),
    .neighbor_output_value        (neighbor_output_value),
    .neighbor_output_row          (neighbor_output_row),
    .neighbor_output_column       (neighbor_output_column),
    .neighbor_output_write_enable (neighbor_output_write_enable)
  );
endmodule
